// File: rtl/riscv_tb_pkg.sv
// Shared types and constants for the riscv_pip instruction stream player.
package riscv_tb_pkg;

  typedef enum logic [1:0] {
    PLAY_SEQ  = 2'd0,
    PLAY_LOOP = 2'd1,
    PLAY_PC   = 2'd2
  } play_mode_e;

  typedef enum {IDLE, RUN, DRAIN, DONE} player_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // The reserved encoding 3 plays back exactly like SEQ.
  function automatic play_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return PLAY_LOOP;
      2'd2:    return PLAY_PC;
      default: return PLAY_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Program buffer: DEPTH x 32, one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module instr_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_player.sv
// Instruction feeder for risc_top's InstrF port: replays a loaded program buffer
// in SEQ (with NOP drain), LOOP or PC-indexed mode, with stall and stop support.
//
// Handshake: there is no valid/ready pair. instr_vld qualifies instr_out as a
// program word in every cycle; stall=1 freezes instr_out/instr_vld/pointer/
// issue_cnt for that cycle (and the drain counter while draining). The start
// edge itself issues the first word, so it appears on instr_out one cycle
// after start is sampled. stop overrides stall while running.
module instr_stream_player
  import riscv_tb_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH),
  parameter int DRAIN_NOPS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [AW:0]      prog_len,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             stall,
  input  logic [31:0]      pc_in,
  output logic [31:0]      instr_out,
  output logic             instr_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam int              DW         = $clog2(DRAIN_NOPS + 2);
  localparam logic [AW:0]     LEN_MAX    = (AW+1)'(DEPTH);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_NOPS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  player_state_e    state_q, state_d;
  play_mode_e       mode_q, mode_d, sel_mode;
  logic [AW-1:0]    ptr_q, ptr_d, sel_ptr, ptr_inc, pc_idx, rd_addr;
  logic [AW:0]      len_q, len_d, len_in, sel_len;
  logic [DW-1:0]    drain_q, drain_d;
  logic [31:0]      instr_q, instr_d, rd_data;
  logic             vld_q, vld_d, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_like, start_ok, ram_we, pc_ok, last_entry, issue;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = start && idle_like;
  assign ram_we    = wr_en && idle_like;
  assign len_in    = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  // On the start edge the issue path uses the freshly sampled settings,
  // afterwards the latched ones.
  assign sel_mode   = start_ok ? decode_mode(mode) : mode_q;
  assign sel_len    = start_ok ? len_in : len_q;
  assign sel_ptr    = start_ok ? '0 : ptr_q;
  assign ptr_inc    = sel_ptr + 1'b1;
  assign last_entry = ({1'b0, sel_ptr} == (sel_len - 1'b1));

  assign pc_idx  = pc_in[AW+1:2];
  assign pc_ok   = (pc_in[1:0] == 2'b00) && (pc_in[31:AW+2] == '0) &&
                   ({1'b0, pc_idx} < sel_len);
  assign rd_addr = (sel_mode == PLAY_PC) ? pc_idx : sel_ptr;

  instr_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state, pointer, counters and output word selection.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    drain_d = drain_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        instr_d = RV_NOP;
        vld_d   = 1'b0;
        if (start) begin
          mode_d  = decode_mode(mode);
          len_d   = len_in;
          ptr_d   = '0;
          drain_d = '0;
          cnt_d   = '0;
          if (len_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            issue   = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          // The NOP issued on the stop edge counts as the first drain NOP.
          state_d = DRAIN;
          drain_d = DW'(1);
          instr_d = RV_NOP;
          vld_d   = 1'b0;
        end else if (!stall) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        instr_d = RV_NOP;
        vld_d   = 1'b0;
        if (!stall) begin
          if (drain_q >= DRAIN_LAST) state_d = DONE;
          else                       drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      if (sel_mode == PLAY_PC) begin
        instr_d = pc_ok ? rd_data : RV_NOP;
        vld_d   = pc_ok;
      end else begin
        instr_d = rd_data;
        vld_d   = 1'b1;
        if (last_entry) begin
          if (sel_mode == PLAY_LOOP) begin
            ptr_d = '0;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          ptr_d = ptr_inc;
        end
      end
      if (vld_d && (cnt_d != CNT_MAX)) cnt_d = cnt_d + 1'b1;
    end
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= PLAY_SEQ;
      len_q   <= '0;
      ptr_q   <= '0;
      drain_q <= '0;
      instr_q <= RV_NOP;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  assign instr_out = instr_q;
  assign instr_vld = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign issue_cnt = cnt_q;

endmodule
